// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration sequencer for the QC-LDPC H-matrix interleaving path.
// Drives en_load / f_one_iteration and the H-matrix ROM address, counts decoder
// iterations, terminates on syndrome result or iteration limit, and reports
// through a start/done handshake.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | one-cycle clear pulse to the interleaving unit
// LOAD   | ROW_GROUPS*SUB_CYCLES load cycles, rom_addr walking 0..N-1
// WAIT   | waiting for the parity-check result
// DONE   | one-cycle completion pulse
module ldpc_iter_ctrl #(
  parameter int ROW_GROUPS = 4,
  parameter int SUB_CYCLES = 4,
  parameter int ADDR_W     = 4,
  parameter int MAX_ITER   = 10,
  parameter int ITER_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_valid,
  input  logic              syndrome_ok,
  input  logic              load_to_interleaving,
  output logic              en_load,
  output logic              f_one_iteration,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              decode_ok,
  output logic              sync_err
);

  localparam int SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROW_GROUPS * SUB_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  // Tracks rom_addr mod SUB_CYCLES without a divider for non-power-of-two sizes.
  logic [SUB_W-1:0] sub;

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      sub             <= '0;
      en_load         <= 1'b0;
      f_one_iteration <= 1'b0;
      rom_addr        <= '0;
      iter_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      decode_ok       <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      f_one_iteration <= 1'b0;
      done            <= 1'b0;

      // The interleaving unit must flag row-group completion exactly on the
      // last sub-load; the check runs even on a LOAD cycle that gets aborted.
      if (state == S_LOAD && (load_to_interleaving != (sub == SUB_LAST))) begin
        sync_err <= 1'b1;
      end

      if (abort && (state == S_INIT || state == S_LOAD || state == S_WAIT)) begin
        state           <= S_IDLE;
        f_one_iteration <= 1'b1;
        en_load         <= 1'b0;
        rom_addr        <= '0;
        busy            <= 1'b0;
        decode_ok       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state           <= S_INIT;
              f_one_iteration <= 1'b1;
              en_load         <= 1'b0;
              rom_addr        <= '0;
              iter_cnt        <= '0;
              sync_err        <= 1'b0;
              decode_ok       <= 1'b0;
              busy            <= 1'b1;
            end
          end
          S_INIT: begin
            state    <= S_LOAD;
            en_load  <= 1'b1;
            rom_addr <= '0;
            sub      <= '0;
          end
          S_LOAD: begin
            if (rom_addr == ADDR_LAST) begin
              state    <= S_WAIT;
              en_load  <= 1'b0;
              rom_addr <= '0;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
              sub      <= (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
            end
          end
          S_WAIT: begin
            if (syndrome_valid) begin
              if (syndrome_ok) begin
                state     <= S_DONE;
                done      <= 1'b1;
                decode_ok <= 1'b1;
                busy      <= 1'b0;
              end else if (iter_cnt == ITER_LAST) begin
                state     <= S_DONE;
                done      <= 1'b1;
                decode_ok <= 1'b0;
                busy      <= 1'b0;
              end else begin
                state           <= S_INIT;
                f_one_iteration <= 1'b1;
                iter_cnt        <= iter_cnt + ITER_W'(1);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Testbench for ldpc_iter_ctrl: builds a per-cycle expected timeline from the
// decode rules (INIT pulse, 16 loads, syndrome wait, DONE) and compares it
// against the DUT cycle by cycle.
module tb_ldpc_iter_ctrl;

  localparam int MAX_ITER = 10;
  localparam int N_ADDR   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       syndrome_valid = 1'b0;
  logic       syndrome_ok = 1'b0;
  logic       load_to_interleaving = 1'b0;
  logic       en_load, f_one_iteration, busy, done, decode_ok, sync_err;
  logic [3:0] rom_addr;
  logic [4:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       f1;
    logic       en;
    logic [3:0] addr;
    logic [4:0] iter;
    logic       busy;
    logic       done;
    logic       dok;
    logic       sync;
  } vec_t;

  typedef struct packed {
    logic start;
    logic abort;
    logic sv;
    logic sok;
    logic l2i;
  } in_t;

  vec_t exp_q[$];
  vec_t obs_q[$];
  in_t  in_q[$];

  // model state carried between builder calls
  logic m_dok, m_sync;
  int   m_iter;

  always #5 clk = ~clk;

  ldpc_iter_ctrl #(
    .ROW_GROUPS(4), .SUB_CYCLES(4), .ADDR_W(4), .MAX_ITER(MAX_ITER), .ITER_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .syndrome_valid(syndrome_valid), .syndrome_ok(syndrome_ok),
    .load_to_interleaving(load_to_interleaving),
    .en_load(en_load), .f_one_iteration(f_one_iteration), .rom_addr(rom_addr),
    .iter_cnt(iter_cnt), .busy(busy), .done(done), .decode_ok(decode_ok),
    .sync_err(sync_err)
  );

  function automatic vec_t mk(input logic f1, input logic en, input int addr, input int iter,
                              input logic b, input logic d, input logic k, input logic s);
    vec_t v;
    v.f1 = f1; v.en = en; v.addr = 4'(addr); v.iter = 5'(iter);
    v.busy = b; v.done = d; v.dok = k; v.sync = s;
    return v;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v.f1 = f_one_iteration; v.en = en_load; v.addr = rom_addr; v.iter = iter_cnt;
    v.busy = busy; v.done = done; v.dok = decode_ok; v.sync = sync_err;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input in_t i, input vec_t e);
    in_q.push_back(i);
    exp_q.push_back(e);
  endtask

  task automatic clear_all();
    in_q.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic push_idle(input int n);
    in_t i;
    repeat (n) begin
      i = '0;
      i.abort = rb();
      i.l2i = rb();
      push(i, mk(0, 0, 0, m_iter, 0, 0, m_dok, m_sync));
    end
  endtask

  // One decode: ok_iter = iteration whose syndrome is ok (out of range = never),
  // bad_it = iteration whose 2nd load carries a false row-group flag.
  task automatic build_decode(input int ok_iter, input int bad_it, input bit rnd_start, input int max_wait);
    in_t i;
    int  w;
    bit  ok;
    m_sync = 1'b0; m_dok = 1'b0; m_iter = 0;
    i = '0; i.start = 1'b1; i.l2i = rb();
    push(i, mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int it = 0; it < MAX_ITER; it++) begin
      m_iter = it;
      i = '0; i.start = rnd_start ? rb() : 1'b0; i.l2i = rb();
      push(i, mk(0, 1, 0, it, 1, 0, 0, m_sync));
      for (int j = 0; j < N_ADDR; j++) begin
        i = '0; i.start = rnd_start ? rb() : 1'b0;
        i.l2i = ((j % 4) == 3);
        if (it == bad_it && j == 1) begin
          i.l2i = 1'b1;
          m_sync = 1'b1;
        end
        if (j < N_ADDR - 1) push(i, mk(0, 1, j + 1, it, 1, 0, 0, m_sync));
        else                push(i, mk(0, 0, 0, it, 1, 0, 0, m_sync));
      end
      w = $urandom_range(0, max_wait);
      repeat (w) begin
        i = '0; i.start = rnd_start ? rb() : 1'b0; i.sok = rb(); i.l2i = rb();
        push(i, mk(0, 0, 0, it, 1, 0, 0, m_sync));
      end
      ok = (it == ok_iter);
      i = '0; i.start = rnd_start ? rb() : 1'b0; i.sv = 1'b1; i.sok = ok; i.l2i = rb();
      if (ok) begin
        m_dok = 1'b1;
        push(i, mk(0, 0, 0, it, 0, 1, 1, m_sync));
        break;
      end else if (it == MAX_ITER - 1) begin
        push(i, mk(0, 0, 0, it, 0, 1, 0, m_sync));
      end else begin
        push(i, mk(1, 0, 0, it + 1, 1, 0, 0, m_sync));
      end
    end
    // DONE cycle: start and abort here must be ignored
    i = '0; i.start = rnd_start ? rb() : 1'b0; i.abort = rnd_start ? rb() : 1'b0;
    push(i, mk(0, 0, 0, m_iter, 0, 0, m_dok, m_sync));
  endtask

  // Replace entry `at` with an abort and drop everything built after it.
  task automatic cut_abort(input int at);
    vec_t prev;
    in_t  i;
    prev = exp_q[at - 1];
    while (in_q.size() > at + 1) in_q.pop_back();
    while (exp_q.size() > at + 1) exp_q.pop_back();
    i = in_q[at];
    i.abort = 1'b1;
    in_q[at] = i;
    exp_q[at] = mk(1, 0, 0, int'(prev.iter), 0, 0, 0, prev.sync);
    m_iter = int'(prev.iter); m_dok = 1'b0; m_sync = prev.sync;
  endtask

  task automatic play();
    obs_q.delete();
    foreach (in_q[n]) begin
      start = in_q[n].start; abort = in_q[n].abort;
      syndrome_valid = in_q[n].sv; syndrome_ok = in_q[n].sok;
      load_to_interleaving = in_q[n].l2i;
      @(posedge clk); #1;
      obs_q.push_back(sample());
    end
    start = 0; abort = 0; syndrome_valid = 0; syndrome_ok = 0; load_to_interleaving = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (sample() !== vec_t'(0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", sample(), vec_t'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_iter = 0; m_dok = 0; m_sync = 0;
    clear_all();
    push_idle(20);
    play();
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_min_latency();
    int first_done, ens, f1s;
    clear_all();
    build_decode(0, -1, 0, 0);
    push_idle(3);
    play();
    first_done = -1; ens = 0; f1s = 0;
    foreach (obs_q[n]) begin
      if (obs_q[n].done && first_done < 0) first_done = n;
      if (obs_q[n].en) ens++;
      if (obs_q[n].f1) f1s++;
    end
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL min_latency cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    // obs index 0 is the cycle after the start edge, so done at index 18 is cycle 19
    checks++;
    if (first_done != 18) begin
      errors++;
      $display("FAIL min_latency_done_index: got %0d expected 18", first_done);
    end
    checks++;
    if (ens != 16 || f1s != 1) begin
      errors++;
      $display("FAIL min_latency_counts: en_load=%0d f_one=%0d expected 16 and 1", ens, f1s);
    end
  endtask

  task automatic test_max_iter();
    int f1s, max_it;
    clear_all();
    build_decode(-1, -1, 0, 2);
    push_idle(2);
    play();
    f1s = 0; max_it = 0;
    foreach (obs_q[n]) begin
      if (obs_q[n].f1) f1s++;
      if (int'(obs_q[n].iter) > max_it) max_it = int'(obs_q[n].iter);
    end
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL max_iter cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    checks++;
    if (f1s != MAX_ITER || max_it != MAX_ITER - 1) begin
      errors++;
      $display("FAIL max_iter_counts: f_one=%0d max iter_cnt=%0d expected %0d and %0d",
               f1s, max_it, MAX_ITER, MAX_ITER - 1);
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    repeat (6) begin
      build_decode($urandom_range(0, MAX_ITER + 1), -1, 1, 3);
      push_idle($urandom_range(0, 2));
    end
    play();
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_sync_err();
    int mid;
    clear_all();
    build_decode(1, 0, 0, 1);
    push_idle(3);
    mid = exp_q.size() - 1;
    build_decode(0, -1, 0, 1);
    push_idle(1);
    play();
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL sync_err cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    checks++;
    if (obs_q[mid].sync !== 1'b1 || obs_q[obs_q.size() - 1].sync !== 1'b0) begin
      errors++;
      $display("FAIL sync_err_hold: held=%b after_restart=%b expected 1 and 0",
               obs_q[mid].sync, obs_q[obs_q.size() - 1].sync);
    end
  endtask

  task automatic test_abort_load();
    int dones;
    clear_all();
    build_decode(0, -1, 0, 0);
    cut_abort(6);   // index 2..17 are LOAD cycles; 6 is the 5th
    push_idle(2);
    build_decode(0, -1, 0, 0);
    push_idle(1);
    play();
    dones = 0;
    foreach (obs_q[n]) if (obs_q[n].done) dones++;
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL abort_load cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL abort_load_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_abort_wait();
    int dones;
    clear_all();
    build_decode(0, -1, 1, 0);
    cut_abort(18);  // first WAIT cycle, syndrome_valid=syndrome_ok=1 as well
    push_idle(2);
    play();
    dones = 0;
    foreach (obs_q[n]) if (obs_q[n].done) dones++;
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL abort_wait cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_wait_done_count: got %0d expected 0", dones);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== vec_t'(0)) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", sample(), vec_t'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_iter = 0; m_dok = 0; m_sync = 0;
    clear_all();
    push_idle(3);
    play();
    foreach (exp_q[n]) begin
      checks++;
      if (obs_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL async_reset_idle cycle %0d: got %h expected %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_max_iter();
    test_back_to_back();
    test_sync_err();
    test_abort_load();
    test_abort_wait();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
